pattern_adc_decoder: RTL and testbench
======================================

// Module: pattern_adc_decoder
// PURPOSE
//  Receive-side counterpart of the DAC pattern/PWM generator. Slices ADC samples into a
//  line level with hysteresis, finds frame starts and samples _PAT_WIDTH fixed-width bit
//  slots. Each decoded frame is reported as a pattern word, plus a frame count and
//  gap-violation errors. Sits after the ADC capture interface, in the loopback/self-test path.
// PARAMETERS
//  _PAT_WIDTH  8   bits per frame / width of pat_out
//  _ADC_WIDTH  8   ADC sample width
// PORTS
//  clk         in   1           system clock
//  rst_n       in   1           asynchronous reset, active low
//  cap_en      in   1           capture enable; low aborts and idles
//  adc_data    in   _ADC_WIDTH  ADC sample, one per clk
//  th_hi       in   _ADC_WIDTH  level rises when adc_q >= th_hi
//  th_lo       in   _ADC_WIDTH  level falls when adc_q <= th_lo
//  duty_num    in   8           slot length = duty_num+1 cycles
//  gap_min     in   16          minimum low cycles between frames
//  frame_num   in   8           frames to capture; 0 = unlimited
//  pat_out     out  _PAT_WIDTH  last decoded pattern, bit0 = first slot
//  pat_valid   out  1           1-cycle pulse, pat_out updated this cycle
//  frame_cnt   out  8           frames decoded since capture start
//  gap_err     out  1           1-cycle pulse on early rise during gap
//  busy        out  1           high in any state except IDLE
//  done        out  1           1-cycle pulse when frame_num reached
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, level 0, all counters 0.
//  Front end: adc_q <= adc_data. level is a register: set if adc_q>=th_hi, clear if adc_q<=th_lo,
//   else hold. Sample -> level latency 2 clk. rise = level & ~level_d.
//  Frame start is a rise; by protocol bit0 of every transmitted pattern is 1.
//  FSM states: IDLE, HUNT, SLOT, GAP.
//  IDLE: if cap_en -> HUNT, frame_cnt<=0, busy<=1.
//  HUNT: on rise -> SLOT, slot_cnt<=1, bit_idx<=0, shift reg cleared.
//   The rise cycle counts as slot_cnt 0.
//  SLOT: slot_cnt counts 0..duty_num. When slot_cnt == duty_num>>1, store level into bit bit_idx.
//   At slot_cnt==duty_num: slot_cnt<=0, bit_idx++.
//   After slot _PAT_WIDTH-1 ends:
//    - pat_out <= shift reg; pat_valid pulse; frame_cnt+1 (8-bit, wraps when frame_num==0).
//    - go to GAP with gap_cnt<=0.
//  GAP: each cycle with level==0 increments gap_cnt (16-bit, saturates at FFFF).
//   Level high before gap_cnt>=gap_min: gap_err pulse -> HUNT (the current high is not a start).
//   On rise with gap_cnt>=gap_min: start the next frame directly (same as the HUNT->SLOT action).
//  Completion: if frame_num!=0 and the incremented frame_cnt==frame_num:
//   done pulses in the same cycle as pat_valid; state -> IDLE, busy<=0.
//  cap_en low in any non-IDLE state: next state IDLE, busy 0.
//   Partial frame discarded, no pat_valid, no done. pat_out and frame_cnt hold.
//  cap_en high while IDLE after done: a new capture starts (frame_cnt cleared).
//  duty_num==0: 1-cycle slots, sample point is slot_cnt 0.
//  gap_min==0: any rise after the last slot starts a frame.
//  Inputs duty_num, gap_min and frame_num must be stable while busy.
//  Async reset mid-frame: immediately back to the reset state above.
// TESTING
//  1 PAT 8'h0B, duty_num=3, gap_min=10, frame_num=2, th 200/50, adc 0/FF
//    -> pat_out=8'h0B twice; frame_cnt=2; done with 2nd pat_valid; busy 0 after.
//  2 duty_num=0, pattern 8'hFF, gap 5 cycles, gap_min=4
//    -> pat_out=8'hFF per frame, no gap_err.
//  3 gap_min=20, level returns high after 8 low cycles
//    -> gap_err 1 pulse; that frame ignored; next rise after a full gap decodes.
//  4 frame_num=0, 300 frames -> frame_cnt wraps FF->00; done never asserts.
//  5 adc ramps 40..210 with one-sample dips to 120 at mid-slot, th 200/50
//    -> hysteresis holds level; pattern correct.
//  6 cap_en low in slot 4 -> IDLE next cycle, no pat_valid.
//    rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/pattern_adc_decoder.sv
// Slices ADC samples into a hysteretic line level and decodes fixed-width slot frames into pattern words.
// Latency: sample -> level 2 clk; pat_valid/done one clk after the last slot's final cycle.
// No backpressure: pat_valid/gap_err/done are single-cycle pulses and must be taken when they appear.
module pattern_adc_decoder #(
  parameter int _PAT_WIDTH = 8,
  parameter int _ADC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_en,
  input  logic [_ADC_WIDTH-1:0]  adc_data,
  input  logic [_ADC_WIDTH-1:0]  th_hi,
  input  logic [_ADC_WIDTH-1:0]  th_lo,
  input  logic [7:0]             duty_num,
  input  logic [15:0]            gap_min,
  input  logic [7:0]             frame_num,
  output logic [_PAT_WIDTH-1:0]  pat_out,
  output logic                   pat_valid,
  output logic [7:0]             frame_cnt,
  output logic                   gap_err,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, HUNT, SLOT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [_ADC_WIDTH-1:0]   adc_q, adc_d;
  logic                    level_q, level_d;
  logic                    level_dly_q, level_dly_d;
  logic [7:0]              slot_cnt_q, slot_cnt_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic [_PAT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [15:0]             gap_cnt_q, gap_cnt_d;
  logic [_PAT_WIDTH-1:0]   pat_out_q, pat_out_d;
  logic                    pat_valid_q, pat_valid_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    gap_err_q, gap_err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    rise;
  logic                    start_frame;
  logic [7:0]              cur_slot, step_slot;
  logic [BW-1:0]           cur_bit, step_bit;
  logic [_PAT_WIDTH-1:0]   cur_shreg, step_shreg;
  logic                    frame_end;
  logic                    run_slot;
  logic [7:0]              frame_cnt_inc;

  assign rise = level_q & ~level_dly_q;

  // A frame may begin from HUNT on any rise, or from GAP once the low gap is long enough.
  assign start_frame = rise && ((state_q == HUNT) ||
                                ((state_q == GAP) && (gap_cnt_q >= gap_min)));

  // Front end: register the sample, then slice with hysteresis (set wins if thresholds overlap).
  always_comb begin
    adc_d       = adc_data;
    level_d     = level_q;
    level_dly_d = level_q;
    if (adc_q >= th_hi) begin
      level_d = 1'b1;
    end else if (adc_q <= th_lo) begin
      level_d = 1'b0;
    end
  end

  // One slot-cycle step; the rise cycle itself is slot 0 of bit 0 with a cleared shift register.
  always_comb begin
    cur_slot  = slot_cnt_q;
    cur_bit   = bit_idx_q;
    cur_shreg = shreg_q;
    if (start_frame) begin
      cur_slot  = '0;
      cur_bit   = '0;
      cur_shreg = '0;
    end
    step_shreg = cur_shreg;
    if (cur_slot == (duty_num >> 1)) begin
      step_shreg[cur_bit] = level_q;
    end
    step_slot = cur_slot + 8'd1;
    step_bit  = cur_bit;
    frame_end = 1'b0;
    if (cur_slot == duty_num) begin
      step_slot = '0;
      step_bit  = cur_bit + BW'(1);
      frame_end = (cur_bit == BW'(_PAT_WIDTH - 1));
    end
  end

  // Capture FSM: next state, counters and output pulses.
  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    gap_cnt_d     = gap_cnt_q;
    pat_out_d     = pat_out_q;
    pat_valid_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    gap_err_d     = 1'b0;
    done_d        = 1'b0;
    run_slot      = 1'b0;
    frame_cnt_inc = frame_cnt_q + 8'd1;

    if ((state_q != IDLE) && !cap_en) begin
      // Abort: partial frame dropped, pat_out and frame_cnt keep their values.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_en) begin
            state_d     = HUNT;
            frame_cnt_d = '0;
          end
        end
        HUNT: begin
          if (start_frame) run_slot = 1'b1;
        end
        SLOT: begin
          run_slot = 1'b1;
        end
        GAP: begin
          if (start_frame) begin
            run_slot = 1'b1;
          end else if (rise) begin
            // Early rise: not a frame start; wait for a fresh rise in HUNT.
            gap_err_d = 1'b1;
            state_d   = HUNT;
          end else if (!level_q && (gap_cnt_q != 16'hFFFF)) begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (run_slot) begin
        state_d    = SLOT;
        slot_cnt_d = step_slot;
        bit_idx_d  = step_bit;
        shreg_d    = step_shreg;
        if (frame_end) begin
          pat_out_d   = step_shreg;
          pat_valid_d = 1'b1;
          frame_cnt_d = frame_cnt_inc;
          gap_cnt_d   = '0;
          state_d     = GAP;
          if ((frame_num != 8'd0) && (frame_cnt_inc == frame_num)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      adc_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      slot_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      gap_cnt_q   <= '0;
      pat_out_q   <= '0;
      pat_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      gap_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_q       <= adc_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      slot_cnt_q  <= slot_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      gap_cnt_q   <= gap_cnt_d;
      pat_out_q   <= pat_out_d;
      pat_valid_q <= pat_valid_d;
      frame_cnt_q <= frame_cnt_d;
      gap_err_q   <= gap_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pat_out   = pat_out_q;
  assign pat_valid = pat_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign gap_err   = gap_err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_adc_decoder.sv
// Directed bench for pattern_adc_decoder: frames are synthesised as ADC sample streams.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Expected values are hand-computed constants per scenario.
module tb_pattern_adc_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_en = 1'b0;
  logic [7:0]  adc_data = 8'h00;
  logic [7:0]  th_hi = 8'd200;
  logic [7:0]  th_lo = 8'd50;
  logic [7:0]  duty_num = 8'd3;
  logic [15:0] gap_min = 16'd10;
  logic [7:0]  frame_num = 8'd0;
  logic [7:0]  pat_out;
  logic        pat_valid;
  logic [7:0]  frame_cnt;
  logic        gap_err;
  logic        busy;
  logic        done;

  pattern_adc_decoder #(._PAT_WIDTH(8), ._ADC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .adc_data(adc_data),
    .th_hi(th_hi), .th_lo(th_lo), .duty_num(duty_num), .gap_min(gap_min),
    .frame_num(frame_num), .pat_out(pat_out), .pat_valid(pat_valid),
    .frame_cnt(frame_cnt), .gap_err(gap_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor state (written only by the monitor).
  int         pv_cnt = 0;
  int         gerr_cnt = 0;
  int         done_cnt = 0;
  int         done_with_pv = 0;
  logic [7:0] last_pat = 8'h00;
  logic [7:0] fc_at_done = 8'h00;
  logic       busy_at_done = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pat_valid) begin
        pv_cnt++;
        last_pat = pat_out;
      end
      if (gap_err) gerr_cnt++;
      if (done) begin
        done_cnt++;
        if (pat_valid) done_with_pv++;
        fc_at_done   = frame_cnt;
        busy_at_done = busy;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] v);
    adc_data = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_low(input int n);
    for (int i = 0; i < n; i++) tick(8'h00);
  endtask

  task automatic send_frame(input logic [7:0] pat);
    for (int b = 0; b < 8; b++)
      for (int j = 0; j <= int'(duty_num); j++)
        tick(pat[b] ? 8'hFF : 8'h00);
  endtask

  // duty_num=3 slots with a 120 dip at the sample point, between the thresholds.
  task automatic send_frame_hyst(input logic [7:0] pat);
    logic [7:0] hi_s [4];
    logic [7:0] lo_s [4];
    hi_s = '{8'd200, 8'd120, 8'd205, 8'd210};
    lo_s = '{8'd40, 8'd120, 8'd45, 8'd50};
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++)
        tick(pat[b] ? hi_s[j] : lo_s[j]);
  endtask

  task automatic stop_capture();
    cap_en = 1'b0;
    send_low(2);
  endtask

  int pv0, ge0, dn0, dp0;

  task automatic snap();
    pv0 = pv_cnt;
    ge0 = gerr_cnt;
    dn0 = done_cnt;
    dp0 = done_with_pv;
  endtask

  initial begin
    // Reset values
    #3;
    check_eq("rst_pat_out", 32'(pat_out), 32'h0);
    check_eq("rst_pat_valid", 32'(pat_valid), 32'h0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done_gap_err", 32'({done, gap_err}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_low(2);

    // 1: 0x0B, duty 3, gap_min 10, two frames then done
    duty_num = 8'd3; gap_min = 16'd10; frame_num = 8'd2;
    snap();
    cap_en = 1'b1;
    send_low(3);
    check_eq("s1_busy_hunt", 32'(busy), 32'h1);
    send_frame(8'h0B);
    send_low(12);
    check_eq("s1_pat1", 32'(last_pat), 32'h0B);
    check_eq("s1_fcnt1", 32'(frame_cnt), 32'h1);
    send_frame(8'h0B);
    send_low(6);
    check_eq("s1_pv_cnt", 32'(pv_cnt - pv0), 32'd2);
    check_eq("s1_pat2", 32'(last_pat), 32'h0B);
    check_eq("s1_done_cnt", 32'(done_cnt - dn0), 32'd1);
    check_eq("s1_done_with_pv", 32'(done_with_pv - dp0), 32'd1);
    check_eq("s1_fcnt_at_done", 32'(fc_at_done), 32'd2);
    check_eq("s1_busy_at_done", 32'(busy_at_done), 32'h0);
    check_eq("s1_gap_err", 32'(gerr_cnt - ge0), 32'd0);
    // cap_en still high: a new capture has started with a cleared count
    check_eq("s1_restart_fcnt", 32'(frame_cnt), 32'd0);
    check_eq("s1_restart_busy", 32'(busy), 32'h1);
    stop_capture();
    check_eq("s1_stop_busy", 32'(busy), 32'h0);

    // 2: duty 0, 0xFF frames, 5-cycle gaps, gap_min 4
    duty_num = 8'd0; gap_min = 16'd4; frame_num = 8'd0;
    snap();
    cap_en = 1'b1;
    send_low(3);
    for (int k = 0; k < 3; k++) begin
      send_frame(8'hFF);
      send_low(5);
    end
    check_eq("s2_pv_cnt", 32'(pv_cnt - pv0), 32'd3);
    check_eq("s2_pat", 32'(last_pat), 32'hFF);
    check_eq("s2_gap_err", 32'(gerr_cnt - ge0), 32'd0);
    check_eq("s2_fcnt", 32'(frame_cnt), 32'd3);
    check_eq("s2_done", 32'(done_cnt - dn0), 32'd0);
    stop_capture();

    // 3: gap_min 20, early return high after 8 low cycles
    duty_num = 8'd3; gap_min = 16'd20; frame_num = 8'd0;
    snap();
    cap_en = 1'b1;
    send_low(3);
    send_frame(8'h0B);
    send_low(8);
    for (int i = 0; i < 4; i++) tick(8'hFF);
    send_low(25);
    send_frame(8'h35);
    send_low(6);
    check_eq("s3_gap_err", 32'(gerr_cnt - ge0), 32'd1);
    check_eq("s3_pv_cnt", 32'(pv_cnt - pv0), 32'd2);
    check_eq("s3_pat", 32'(last_pat), 32'h35);
    check_eq("s3_fcnt", 32'(frame_cnt), 32'd2);
    stop_capture();

    // 4: unlimited capture, 300 back-to-back frames, frame_cnt wraps
    duty_num = 8'd0; gap_min = 16'd0; frame_num = 8'd0;
    snap();
    cap_en = 1'b1;
    send_low(3);
    for (int k = 0; k < 300; k++) send_frame(8'h01);
    send_low(4);
    check_eq("s4_pv_cnt", 32'(pv_cnt - pv0), 32'd300);
    check_eq("s4_fcnt_wrap", 32'(frame_cnt), 32'd44);
    check_eq("s4_pat", 32'(last_pat), 32'h01);
    check_eq("s4_done", 32'(done_cnt - dn0), 32'd0);
    check_eq("s4_gap_err", 32'(gerr_cnt - ge0), 32'd0);
    stop_capture();

    // 5: hysteresis with mid-slot dips to 120
    duty_num = 8'd3; gap_min = 16'd4; frame_num = 8'd2;
    snap();
    cap_en = 1'b1;
    send_low(3);
    send_frame_hyst(8'hA5);
    send_low(10);
    check_eq("s5_pat1", 32'(last_pat), 32'hA5);
    send_frame_hyst(8'h5B);
    send_low(6);
    check_eq("s5_pat2", 32'(last_pat), 32'h5B);
    check_eq("s5_pv_cnt", 32'(pv_cnt - pv0), 32'd2);
    check_eq("s5_done", 32'(done_cnt - dn0), 32'd1);
    check_eq("s5_fcnt_at_done", 32'(fc_at_done), 32'd2);
    stop_capture();

    // 6a: cap_en dropped mid-frame
    duty_num = 8'd3; gap_min = 16'd4; frame_num = 8'd0;
    snap();
    cap_en = 1'b1;
    send_low(3);
    send_frame(8'h0B);
    send_low(6);
    for (int i = 0; i < 19; i++) tick(((i / 4) % 2 == 0) ? 8'hFF : 8'h00);
    cap_en = 1'b0;
    tick(8'hFF);
    check_eq("s6_abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 12; i++) tick(8'h00);
    send_low(4);
    check_eq("s6_abort_pv", 32'(pv_cnt - pv0), 32'd1);
    check_eq("s6_abort_pat_hold", 32'(pat_out), 32'h0B);
    check_eq("s6_abort_fcnt_hold", 32'(frame_cnt), 32'd1);
    check_eq("s6_abort_done", 32'(done_cnt - dn0), 32'd0);

    // 6b: asynchronous reset mid-frame
    cap_en = 1'b1;
    send_low(3);
    send_frame(8'h0B);
    send_low(6);
    for (int i = 0; i < 10; i++) tick(8'hFF);
    check_eq("s6_pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_pat_out", 32'(pat_out), 32'h0);
    check_eq("s6_rst_fcnt", 32'(frame_cnt), 32'h0);
    check_eq("s6_rst_busy", 32'(busy), 32'h0);
    check_eq("s6_rst_pulses", 32'({pat_valid, gap_err, done}), 32'h0);
    cap_en = 1'b0;
    #10;
    rst_n = 1'b1;
    send_low(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
